// File: rtl/srlfifo32x18.sv
// rtl/srlfifo32x18.sv - 32x18 shift-register FIFO with first-word fall-through output
// Optional sticky overflow flag enabled by defining SRLFIFO_ERR_EN.
module srlfifo32x18 #(
  parameter int AF_LVL = 28,
  parameter int AE_LVL = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [17:0] d,
  input  logic        iv,
  output logic        ir,
  output logic [17:0] y,
  output logic        ov,
  input  logic        ordy,
  output logic [5:0]  cnt,
  output logic        af,
  output logic        ae,
  output logic        err
);

  localparam logic [5:0] AF_C = 6'(AF_LVL);
  localparam logic [5:0] AE_C = 6'(AE_LVL);

  logic [31:0][17:0] srl_q, srl_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [4:0]        rd_addr;
  logic              wr, rd;

  // Occupancy never exceeds 32, so bit 5 alone marks the full state.
  assign ir      = ~cnt_q[5];
  assign ov      = |cnt_q;
  assign wr      = iv & ir;
  assign rd      = ov & ordy;
  assign rd_addr = cnt_q[4:0] - 5'd1;
  assign y       = ov ? srl_q[rd_addr] : 18'd0;
  assign cnt     = cnt_q;
  assign af      = (cnt_q >= AF_C);
  assign ae      = (cnt_q <= AE_C);

  always_comb begin
    srl_d = srl_q;
    if (wr) srl_d = {srl_q[30:0], d};
    cnt_d = cnt_q;
    case ({wr, rd})
      2'b10:   cnt_d = cnt_q + 6'd1;
      2'b01:   cnt_d = cnt_q - 6'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage carries no reset so it maps onto SRL primitives.
  always_ff @(posedge clk) begin
    srl_q <= srl_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 6'd0;
    else        cnt_q <= cnt_d;
  end

`ifdef SRLFIFO_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (iv & ~ir);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_srlfifo32x18.sv
// tb/tb_srlfifo32x18.sv - randomized self-checking bench for srlfifo32x18 against a queue model
module tb_srlfifo32x18;

  localparam int AF_LVL = 28;
  localparam int AE_LVL = 2;
`ifdef SRLFIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] d = 18'd0;
  logic        iv = 1'b0;
  logic        ordy = 1'b0;
  logic        ir, ov, af, ae, err;
  logic [17:0] y;
  logic [5:0]  cnt;

  srlfifo32x18 #(.AF_LVL(AF_LVL), .AE_LVL(AE_LVL)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .iv(iv), .ir(ir), .y(y), .ov(ov),
    .ordy(ordy), .cnt(cnt), .af(af), .ae(ae), .err(err)
  );

  always #5 clk = ~clk;

  logic [17:0] mq[$];
  bit          merr = 1'b0;
  int          n_cmp = 0;
  int          n_fail = 0;

  wire [28:0] act_vec = {cnt, ov, ir, af, ae, err, y};

  function automatic logic [28:0] exp_vec();
    int n;
    logic [17:0] head;
    n = mq.size();
    head = (n != 0) ? mq[0] : 18'd0;
    return {6'(n), n != 0, n < 32, n >= AF_LVL, n <= AE_LVL, merr, head};
  endfunction

  task automatic step(input bit v, input logic [17:0] dv, input bit r);
    bit w, rr;
    iv = v; d = dv; ordy = r;
    @(posedge clk);
    w  = v && (mq.size() < 32);
    rr = r && (mq.size() > 0);
    if (v && mq.size() == 32 && ERR_EN) merr = 1'b1;
    if (rr) void'(mq.pop_front());
    if (w) mq.push_back(dv);
    @(negedge clk);
    iv = 1'b0; ordy = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (act_vec !== {6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 18'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", act_vec, {6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 18'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 5; i++) step(1'b1, 18'(i), 1'b0);
    n_cmp++;
    if ({cnt, y, ov, ae} !== {6'd5, 18'h00001, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_fill: got cnt=%0d y=%h ov=%b ae=%b expected 5 00001 1 0", cnt, y, ov, ae);
    end
    for (int i = 1; i <= 5; i++) begin
      n_cmp++;
      if ({ov, y} !== {1'b1, 18'(i)}) begin
        n_fail++;
        $display("FAIL basic_read: got ov=%b y=%h expected 1 %h", ov, y, 18'(i));
      end
      step(1'b0, 18'd0, 1'b1);
    end
    n_cmp++;
    if ({ov, y, cnt} !== 25'd0) begin
      n_fail++;
      $display("FAIL basic_empty: got ov=%b y=%h cnt=%0d expected 0 0 0", ov, y, cnt);
    end
  endtask

  task automatic test_empty_edges();
    step(1'b0, 18'd0, 1'b1);
    step(1'b0, 18'd0, 1'b1);
    n_cmp++;
    if ({cnt, ov} !== 7'd0) begin
      n_fail++;
      $display("FAIL empty_read: got cnt=%0d ov=%b expected 0 0", cnt, ov);
    end
    step(1'b1, 18'h0BEEF, 1'b1);
    n_cmp++;
    if ({cnt, ov, y} !== {6'd1, 1'b1, 18'h0BEEF}) begin
      n_fail++;
      $display("FAIL write_empty_ordy: got cnt=%0d ov=%b y=%h expected 1 1 0beef", cnt, ov, y);
    end
    step(1'b0, 18'd0, 1'b1);
  endtask

  task automatic test_full();
    for (int i = 0; i < 32; i++) step(1'b1, 18'h3FFFF - 18'(i), 1'b0);
    n_cmp++;
    if ({ir, af, cnt} !== {1'b0, 1'b1, 6'd32}) begin
      n_fail++;
      $display("FAIL full_flags: got ir=%b af=%b cnt=%0d expected 0 1 32", ir, af, cnt);
    end
    step(1'b1, 18'h15555, 1'b0);
    n_cmp++;
    if ({cnt, err} !== {6'd32, ERR_EN}) begin
      n_fail++;
      $display("FAIL full_overflow: got cnt=%0d err=%b expected 32 %b", cnt, err, ERR_EN);
    end
    n_cmp++;
    if (y !== 18'h3FFFF) begin
      n_fail++;
      $display("FAIL full_first_read: got %h expected 3ffff", y);
    end
    for (int k = 0; k < 40 && mq.size() > 0; k++) begin
      n_cmp++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL full_drain: got %h expected %h", act_vec, exp_vec());
      end
      step(1'b0, 18'd0, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] exp_next;
    for (int i = 0; i < 10; i++) step(1'b1, 18'd100 + 18'(i), 1'b0);
    exp_next = 18'd100;
    for (int k = 0; k < 20; k++) begin
      n_cmp++;
      if ({cnt, ov, y} !== {6'd10, 1'b1, exp_next}) begin
        n_fail++;
        $display("FAIL back_to_back: got cnt=%0d ov=%b y=%h expected 10 1 %h", cnt, ov, y, exp_next);
      end
      exp_next = exp_next + 18'd1;
      step(1'b1, 18'd110 + 18'(k), 1'b1);
    end
    for (int k = 0; k < 40 && mq.size() > 0; k++) begin
      n_cmp++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b_drain: got %h expected %h", act_vec, exp_vec());
      end
      step(1'b0, 18'd0, 1'b1);
    end
  endtask

  task automatic test_random();
    int pw, pr;
    pw = 50; pr = 50;
    for (int k = 0; k < 800; k++) begin
      if (k % 50 == 0) begin
        pw = $urandom_range(10, 90);
        pr = $urandom_range(10, 90);
      end
      n_cmp++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h expected %h", k, act_vec, exp_vec());
      end
      step($urandom_range(0, 99) < pw, 18'($urandom), $urandom_range(0, 99) < pr);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 40 && mq.size() > 7; k++) step(1'b0, 18'd0, 1'b1);
    for (int k = 0; k < 40 && mq.size() < 7; k++) step(1'b1, 18'($urandom), 1'b0);
    n_cmp++;
    if (cnt !== 6'd7) begin
      n_fail++;
      $display("FAIL mid_pre: got cnt=%0d expected 7", cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cnt, ov, y, err, ir, ae} !== {6'd0, 1'b0, 18'd0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_reset: got cnt=%0d ov=%b y=%h err=%b ir=%b ae=%b expected 0 0 0 0 1 1", cnt, ov, y, err, ir, ae);
    end
    mq.delete();
    merr = 1'b0;
    #1 rst_n = 1'b1;
    step(1'b1, 18'h2AAAA, 1'b0);
    n_cmp++;
    if ({cnt, ov, y} !== {6'd1, 1'b1, 18'h2AAAA}) begin
      n_fail++;
      $display("FAIL mid_rewrite: got cnt=%0d ov=%b y=%h expected 1 1 2aaaa", cnt, ov, y);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_edges();
    test_full();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
